gs_cmd_streamer: RTL and testbench

Generator-side streaming engine between the host-to-FPGA command FIFO and the FPGA-to-host raw-signal FIFO on the PEATC Xillinux design. It pops one 32-bit test command from the RX FIFO. It then reads a window of 16-bit raw-signal samples from the synchronous sample memory, once per repetition requested. Each sample is byte-swapped for the host and pushed into the TX FIFO, with TX back-pressure honoured. Runs entirely on `bus_clk`; `iReset` is driven from the host FPGA-reset device open flag.

---
 rtl/gs_cmd_streamer.sv | 112 +++++++++++
 tb/tb_gs_cmd_streamer.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gs_cmd_streamer.sv
// Command-driven sample streamer: pops a command from the RX FIFO, then reads a window of
// sample memory R times and pushes each byte-swapped word into the TX FIFO.
module gs_cmd_streamer (
    input  logic        iClk,
    input  logic        iReset,
    input  logic [31:0] iGS_32NewCmdData,
    input  logic        iGS_CmdEmpty,
    output logic        oGS_FifoReadEn,
    output logic [31:0] oGS_32Cmd,
    output logic [7:0]  oGS_8Addr,
    output logic        oGS_MemRdEn,
    input  logic [15:0] iGS_16Sample,
    input  logic        iGS_TxFull,
    output logic        oGS_WriteRawSignal,
    output logic [15:0] oGS_16RawSignal,
    output logic        oGS_Busy,
    output logic        oGS_CmdErr
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_CHECK, S_RD, S_CAP, S_WR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cmd_q, cmd_d;
    logic [7:0]  k_q, k_d;
    logic [7:0]  r_q, r_d;
    logic [15:0] raw_q, raw_d;

    logic [7:0] cmd_reps, cmd_start, cmd_count;
    logic       cmd_bad, last_k, last_r, tx_go;

    assign cmd_reps  = cmd_q[23:16];
    assign cmd_start = cmd_q[15:8];
    assign cmd_count = cmd_q[7:0];
    assign cmd_bad   = (cmd_count == 8'd0) || (cmd_reps == 8'd0);
    // CHECK has already rejected zero counts, so the minus-one terms cannot underflow.
    assign last_k    = !(k_q < cmd_count - 8'd1);
    assign last_r    = !(r_q < cmd_reps - 8'd1);
    // The full flag gates the write in the same cycle so a write can never land on a full FIFO.
    assign tx_go     = (state_q == S_WR) && !iGS_TxFull;

    always_ff @(posedge iClk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (iReset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            k_q     <= '0;
            r_q     <= '0;
            raw_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            k_q     <= k_d;
            r_q     <= r_d;
            raw_q   <= raw_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!iGS_CmdEmpty) state_d = S_FETCH;
            S_FETCH: state_d = S_LATCH;
            S_LATCH: state_d = S_CHECK;
            S_CHECK: state_d = cmd_bad ? S_IDLE : S_RD;
            S_RD:    state_d = S_CAP;
            S_CAP:   state_d = S_WR;
            S_WR: begin
                if (tx_go) state_d = (last_k && last_r) ? S_IDLE : S_RD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_d = cmd_q;
        k_d   = k_q;
        r_d   = r_q;
        raw_d = raw_q;
        case (state_q)
            S_LATCH: begin
                cmd_d = iGS_32NewCmdData;
                k_d   = '0;
                r_d   = '0;
            end
            S_CAP: raw_d = {iGS_16Sample[7:0], iGS_16Sample[15:8]};
            S_WR: begin
                if (tx_go && !last_k) begin
                    k_d = k_q + 8'd1;
                end else if (tx_go && !last_r) begin
                    k_d = '0;
                    r_d = r_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        oGS_FifoReadEn     = (state_q == S_FETCH);
        oGS_MemRdEn        = (state_q == S_RD);
        oGS_WriteRawSignal = tx_go;
        oGS_Busy           = (state_q != S_IDLE);
        oGS_CmdErr         = (state_q == S_CHECK) && cmd_bad;
        oGS_32Cmd          = cmd_q;
        oGS_8Addr          = cmd_start + k_q;
        oGS_16RawSignal    = raw_q;
    end

endmodule

// File: tb/tb_gs_cmd_streamer.sv
// Bench for gs_cmd_streamer: RX FIFO, sample memory and TX monitor models with a
// list-based reference of the words each command must produce.
module tb_gs_cmd_streamer;

    logic        iClk;
    logic        iReset;
    logic [31:0] rx_dout;
    logic        iGS_CmdEmpty;
    logic [15:0] mem_dout;
    logic        tx_full;
    logic        oGS_FifoReadEn, oGS_MemRdEn, oGS_WriteRawSignal, oGS_Busy, oGS_CmdErr;
    logic [31:0] oGS_32Cmd;
    logic [7:0]  oGS_8Addr;
    logic [15:0] oGS_16RawSignal;

    gs_cmd_streamer dut (
        .iClk               (iClk),
        .iReset             (iReset),
        .iGS_32NewCmdData   (rx_dout),
        .iGS_CmdEmpty       (iGS_CmdEmpty),
        .oGS_FifoReadEn     (oGS_FifoReadEn),
        .oGS_32Cmd          (oGS_32Cmd),
        .oGS_8Addr          (oGS_8Addr),
        .oGS_MemRdEn        (oGS_MemRdEn),
        .iGS_16Sample       (mem_dout),
        .iGS_TxFull         (tx_full),
        .oGS_WriteRawSignal (oGS_WriteRawSignal),
        .oGS_16RawSignal    (oGS_16RawSignal),
        .oGS_Busy           (oGS_Busy),
        .oGS_CmdErr         (oGS_CmdErr)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_push_cyc = 0;

    logic [31:0] rx_mem [0:63];
    int          rx_wr = 0;
    int          rx_rd = 0;
    logic [15:0] mem [0:255];
    logic [15:0] exp_q [$];

    assign iGS_CmdEmpty = (rx_wr == rx_rd);

    always @(posedge iClk) begin
        cyc <= cyc + 1;
        if (oGS_FifoReadEn) begin
            rx_dout <= rx_mem[rx_rd % 64];
            rx_rd   <= rx_rd + 1;
        end
        if (oGS_MemRdEn) mem_dout <= mem[oGS_8Addr];
    end

    logic [15:0] wr_data_q [$];
    int          wr_cyc_q [$];
    logic [7:0]  addr_q [$];
    int          fetch_cyc_q [$];
    int          rd_count = 0;
    int          err_count = 0;
    int          full_viol = 0;
    int          busy_fall_cyc = 0;
    logic        prev_busy = 1'b0;

    always @(negedge iClk) begin
        if (oGS_WriteRawSignal) begin
            wr_data_q.push_back(oGS_16RawSignal);
            wr_cyc_q.push_back(cyc);
            if (tx_full) full_viol++;
        end
        if (oGS_MemRdEn) addr_q.push_back(oGS_8Addr);
        if (oGS_FifoReadEn) begin
            rd_count++;
            fetch_cyc_q.push_back(cyc);
        end
        if (oGS_CmdErr) err_count++;
        if (prev_busy && !oGS_Busy) busy_fall_cyc = cyc;
        prev_busy = oGS_Busy;
    end

    task automatic drive_edge();
        @(posedge iClk);
        #1;
    endtask

    task automatic tick();
        @(negedge iClk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] c);
        drive_edge();
        rx_mem[rx_wr % 64] = c;
        rx_wr++;
        last_push_cyc = cyc;
    endtask

    function automatic logic [15:0] swap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    // Reference: R passes over C consecutive addresses starting at S, wrapping at 256.
    task automatic expect_cmd(input logic [31:0] c);
        int reps, cnt, s;
        reps = int'(c[23:16]);
        cnt  = int'(c[7:0]);
        s    = int'(c[15:8]);
        for (int rep = 0; rep < reps; rep++)
            for (int k = 0; k < cnt; k++)
                exp_q.push_back(swap16(mem[(s + k) % 256]));
    endtask

    task automatic wait_idle(input int target, input int budget, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(rd_count >= target && !oGS_Busy && iGS_CmdEmpty) && n < budget);
        if (!(rd_count >= target && !oGS_Busy && iGS_CmdEmpty)) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout reads=%0d need=%0d busy=%b", name, rd_count, target, oGS_Busy);
        end
    endtask

    task automatic test_reset();
        int wb;
        wb = wr_data_q.size();
        exp_q.delete();
        expect_cmd(32'h09_01_33_01);
        push_cmd(32'h09_01_33_01);
        repeat (3) tick();
        checks++;
        if ({oGS_FifoReadEn, oGS_MemRdEn, oGS_WriteRawSignal, oGS_Busy, oGS_CmdErr,
             oGS_32Cmd, oGS_8Addr, oGS_16RawSignal} !== 61'd0) begin
            errors++;
            $display("FAIL reset_outputs got cmd=%h addr=%h raw=%h rd=%b busy=%b exp all zero",
                     oGS_32Cmd, oGS_8Addr, oGS_16RawSignal, oGS_FifoReadEn, oGS_Busy);
        end
        checks++;
        if (rd_count !== 0) begin
            errors++;
            $display("FAIL reset_no_read got=%0d exp=0", rd_count);
        end
        drive_edge();
        iReset = 1'b0;
        wait_idle(1, 50, "reset");
        checks++;
        if (wr_data_q.size() - wb !== 1 || wr_data_q[wb] !== exp_q[0]) begin
            errors++;
            $display("FAIL reset_release_write got n=%0d d=%h exp n=1 d=%h",
                     wr_data_q.size() - wb, wr_data_q[wb], exp_q[0]);
        end
    endtask

    task automatic test_basic();
        logic [31:0] c;
        int wb, rb;
        c  = 32'h05011004;
        wb = wr_data_q.size();
        rb = rd_count;
        exp_q.delete();
        expect_cmd(c);
        push_cmd(c);
        wait_idle(rb + 1, 100, "basic");
        checks++;
        if (wr_data_q.size() - wb !== 4) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=4", wr_data_q.size() - wb);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (wr_data_q[wb + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_data[%0d] got=%h exp=%h", i, wr_data_q[wb + i], exp_q[i]);
            end
        end
        checks++;
        if (wr_cyc_q[wb] !== last_push_cyc + 6) begin
            errors++;
            $display("FAIL basic_first_latency got=%0d exp=%0d", wr_cyc_q[wb], last_push_cyc + 6);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (wr_cyc_q[wb + i] - wr_cyc_q[wb + i - 1] !== 3) begin
                errors++;
                $display("FAIL basic_spacing[%0d] got=%0d exp=3", i, wr_cyc_q[wb + i] - wr_cyc_q[wb + i - 1]);
            end
        end
        checks++;
        if (oGS_32Cmd !== c) begin
            errors++;
            $display("FAIL basic_cmd got=%h exp=%h", oGS_32Cmd, c);
        end
    endtask

    task automatic test_repeat();
        logic [31:0] c;
        int wb, rb;
        c  = {8'($urandom), 8'd3, 8'h20, 8'd2};
        wb = wr_data_q.size();
        rb = rd_count;
        exp_q.delete();
        expect_cmd(c);
        push_cmd(c);
        wait_idle(rb + 1, 100, "repeat");
        checks++;
        if (wr_data_q.size() - wb !== 6) begin
            errors++;
            $display("FAIL repeat_count got=%0d exp=6", wr_data_q.size() - wb);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (wr_data_q[wb + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL repeat_data[%0d] got=%h exp=%h", i, wr_data_q[wb + i], exp_q[i]);
            end
            if (i > 0) begin
                checks++;
                if (wr_cyc_q[wb + i] - wr_cyc_q[wb + i - 1] !== 3) begin
                    errors++;
                    $display("FAIL repeat_spacing[%0d] got=%0d exp=3", i, wr_cyc_q[wb + i] - wr_cyc_q[wb + i - 1]);
                end
            end
        end
        checks++;
        if (busy_fall_cyc !== wr_cyc_q[wb + 5] + 1) begin
            errors++;
            $display("FAIL repeat_busy_fall got=%0d exp=%0d", busy_fall_cyc, wr_cyc_q[wb + 5] + 1);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] c;
        int wb, ab, rb;
        c  = 32'h07_01_FE_04;
        wb = wr_data_q.size();
        ab = addr_q.size();
        rb = rd_count;
        exp_q.delete();
        expect_cmd(c);
        push_cmd(c);
        wait_idle(rb + 1, 100, "wrap");
        checks++;
        if (addr_q.size() - ab !== 4 || wr_data_q.size() - wb !== 4) begin
            errors++;
            $display("FAIL wrap_count got addr=%0d wr=%0d exp 4 and 4", addr_q.size() - ab, wr_data_q.size() - wb);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_q[ab + i] !== 8'((254 + i) % 256) || wr_data_q[wb + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap[%0d] got a=%h d=%h exp a=%h d=%h", i, addr_q[ab + i],
                         wr_data_q[wb + i], 8'((254 + i) % 256), exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] c;
        int wb, rb, f, n;
        c  = 32'h03_01_40_03;
        wb = wr_data_q.size();
        rb = rd_count;
        exp_q.delete();
        expect_cmd(c);
        push_cmd(c);
        n = 0;
        while (rd_count == rb && n < 20) begin
            tick();
            n++;
        end
        f = fetch_cyc_q[rb];
        n = 0;
        while (cyc < f + 7 && n < 20) begin
            tick();
            n++;
        end
        drive_edge();
        tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (oGS_WriteRawSignal !== 1'b0 || oGS_16RawSignal !== exp_q[1]) begin
                errors++;
                $display("FAIL bp_stall[%0d] got wr=%b d=%h exp wr=0 d=%h", i, oGS_WriteRawSignal,
                         oGS_16RawSignal, exp_q[1]);
            end
        end
        drive_edge();
        tx_full = 1'b0;
        wait_idle(rb + 1, 100, "bp");
        checks++;
        if (wr_data_q.size() - wb !== 3) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=3", wr_data_q.size() - wb);
        end
        checks++;
        if (wr_cyc_q[wb] !== f + 5 || wr_cyc_q[wb + 1] !== f + 13 || wr_cyc_q[wb + 2] !== f + 16) begin
            errors++;
            $display("FAIL bp_timing got=%0d,%0d,%0d exp=%0d,%0d,%0d", wr_cyc_q[wb], wr_cyc_q[wb + 1],
                     wr_cyc_q[wb + 2], f + 5, f + 13, f + 16);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_data_q[wb + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_data[%0d] got=%h exp=%h", i, wr_data_q[wb + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_cmd_err();
        int wb, rb, eb;
        wb = wr_data_q.size();
        rb = rd_count;
        eb = err_count;
        push_cmd(32'h12_03_00_00);
        push_cmd(32'h12_00_05_04);
        wait_idle(rb + 2, 100, "err");
        checks++;
        if (err_count - eb !== 2 || wr_data_q.size() - wb !== 0 || rd_count - rb !== 2) begin
            errors++;
            $display("FAIL err_counts got err=%0d wr=%0d rd=%0d exp err=2 wr=0 rd=2",
                     err_count - eb, wr_data_q.size() - wb, rd_count - rb);
        end
        checks++;
        if (oGS_32Cmd !== 32'h12_00_05_04) begin
            errors++;
            $display("FAIL err_cmd got=%h exp=%h", oGS_32Cmd, 32'h12_00_05_04);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] c1, c2;
        int wb, rb, n;
        c1 = 32'h01_01_30_0A;
        c2 = 32'h02_01_50_02;
        wb = wr_data_q.size();
        rb = rd_count;
        exp_q.delete();
        expect_cmd(c1);
        push_cmd(c1);
        push_cmd(c2);
        n = 0;
        while (wr_data_q.size() - wb < 3 && n < 100) begin
            tick();
            n++;
        end
        drive_edge();
        iReset = 1'b1;
        drive_edge();
        iReset = 1'b0;
        tick();
        checks++;
        if ({oGS_FifoReadEn, oGS_MemRdEn, oGS_WriteRawSignal, oGS_Busy, oGS_CmdErr,
             oGS_32Cmd, oGS_8Addr, oGS_16RawSignal} !== 61'd0) begin
            errors++;
            $display("FAIL midreset_outputs got cmd=%h addr=%h raw=%h busy=%b exp all zero",
                     oGS_32Cmd, oGS_8Addr, oGS_16RawSignal, oGS_Busy);
        end
        exp_q = exp_q[0:2];
        expect_cmd(c2);
        wait_idle(rb + 2, 100, "midreset");
        checks++;
        if (wr_data_q.size() - wb !== 5 || rd_count - rb !== 2) begin
            errors++;
            $display("FAIL midreset_counts got wr=%0d rd=%0d exp wr=5 rd=2", wr_data_q.size() - wb, rd_count - rb);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (wr_data_q[wb + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midreset_data[%0d] got=%h exp=%h", i, wr_data_q[wb + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] c;
        int wb, rb, eb, n_err, n;
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        wb = wr_data_q.size();
        rb = rd_count;
        eb = err_count;
        n_err = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            c = {8'($urandom), 8'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 5))};
            if (i == 0) c[15:8] = 8'hFD;
            if (c[23:16] == 8'd0 || c[7:0] == 8'd0) n_err++;
            expect_cmd(c);
            push_cmd(c);
        end
        n = 0;
        while (!(rd_count >= rb + 8 && !oGS_Busy && iGS_CmdEmpty) && n < 2000) begin
            drive_edge();
            tx_full = ($urandom_range(0, 3) == 0);
            tick();
            n++;
        end
        tx_full = 1'b0;
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL rand_timeout reads=%0d need=%0d", rd_count - rb, 8);
        end
        checks++;
        if (wr_data_q.size() - wb !== exp_q.size() || err_count - eb !== n_err) begin
            errors++;
            $display("FAIL rand_counts got wr=%0d err=%0d exp wr=%0d err=%0d",
                     wr_data_q.size() - wb, err_count - eb, exp_q.size(), n_err);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (wr_data_q[wb + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_data[%0d] got=%h exp=%h", i, wr_data_q[wb + i], exp_q[i]);
            end
        end
        checks++;
        if (full_viol !== 0) begin
            errors++;
            $display("FAIL write_while_full got=%0d exp=0", full_viol);
        end
    endtask

    initial begin
        iReset  = 1'b1;
        tx_full = 1'b0;
        rx_dout = '0;
        for (int a = 0; a < 256; a++) mem[a] = 16'h1000 + 16'(a);
        test_reset();
        test_basic();
        test_repeat();
        test_wrap();
        test_backpressure();
        test_cmd_err();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
